// File: rtl/shift_add_mul_ctrl_if.sv
// Request/response bundle between a multiply request source and the
// shift-and-add sequencing controller.
interface shift_add_mul_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                   start;
    logic                   abort;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    // Request source drives operands and control, observes status/result
    modport master (
        output start, abort, multiplicand, multiplier,
        input  busy, done, product
    );

    // Controller consumes the request, publishes status/result
    modport slave (
        input  start, abort, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_mul_ctrl.sv
// Sequential shift-and-add multiplier controller: one conditional add plus
// right shift of {C,A,Q} per clock, WIDTH iterations, registered product.
module shift_add_mul_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_mul_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic                 c_q, c_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       sum;

    // Next-state and datapath: capture on accept, add/shift in RUN, publish on last step
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = done_q;
        // Full WIDTH+1-bit add so the carry out of A lands in the shifted A
        sum     = {c_q, a_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    m_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    // Cancel wins even over the final iteration: product untouched
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    a_d   = sum[WIDTH:1];
                    q_d   = {sum[0], q_q[WIDTH-1:1]};
                    c_d   = 1'b0;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        prod_d  = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;
endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Randomized scoreboard bench for shift_add_mul_ctrl.
module tb_shift_add_mul_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_add_mul_ctrl_if #(.WIDTH(W)) bus ();

    shift_add_mul_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference: phase 0 idle, 1..W running, W+1 result cycle
    int           phase = 0;
    logic [31:0]  pending = '0;
    logic [31:0]  exp_prod = '0;
    logic [31:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the handshake and arithmetic
    always @(posedge clk) begin
        if (!rst_n) begin
            phase    = 0;
            exp_prod = '0;
            exp_q.delete();
        end else if (phase == 0) begin
            if (bus.start && !bus.abort) begin
                pending = {16'd0, bus.multiplicand} * {16'd0, bus.multiplier};
                phase   = 1;
            end
        end else if (phase <= W) begin
            if (bus.abort) phase = 0;
            else if (phase == W) begin
                exp_q.push_back(pending);
                exp_prod = pending;
                phase    = W + 1;
            end else phase++;
        end else begin
            phase = 0;
        end
    end

    // Monitor: per-cycle status checks and scoreboard pop on each done pulse
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'((phase >= 1) && (phase <= W)));
            chk("done", 32'(bus.done), 32'(phase == W + 1));
            chk("product_hold", bus.product, exp_prod);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("scoreboard", bus.product, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (phase != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (phase != 0) chk("idle_timeout", 32'(phase), 32'd0);
    endtask

    // One request; abort_k / rst_k pick the edge E0+k where abort / reset is sampled
    task automatic do_op(input logic [15:0] m, input logic [15:0] q,
                         input int abort_k, input int rst_k);
        wait_idle();
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.multiplicand = 16'($urandom);
        bus.multiplier   = 16'($urandom);
        for (int i = 1; i <= W + 2; i++) begin
            if (i == abort_k) bus.abort = 1'b1;
            if (i == rst_k)   rst_n = 1'b0;
            @(negedge clk);
            bus.abort = 1'b0;
            rst_n     = 1'b1;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'd3, 16'd5, 0, 0);
        do_op(16'hFFFF, 16'hFFFF, 0, 0);
        do_op(16'h8000, 16'h0002, 0, 0);
        do_op(16'h0000, 16'hABCD, 0, 0);
        do_op(16'h1234, 16'h0001, 0, 0);
        do_op(16'd3, 16'd5, 0, 0);
        do_op(16'd7, 16'd9, 8, 0);
        do_op(16'd7, 16'd9, W, 0);
        do_op(16'd7, 16'd9, 1, 0);
        do_op(16'd11, 16'd13, W + 1, 0);
        do_op(16'hFFFF, 16'hFFFF, 0, 5);
        do_op(16'd3, 16'd5, 0, 0);

        // start together with abort in IDLE must be ignored
        wait_idle();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.multiplicand = 16'd100;
        bus.multiplier   = 16'd100;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);

        // start held high with operands changing every cycle
        wait_idle();
        bus.start = 1'b1;
        for (int i = 0; i < 4 * (W + 2) + 3; i++) begin
            bus.multiplicand = 16'($urandom);
            bus.multiplier   = 16'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;

        // random operands, occasional abort at a random iteration
        for (int i = 0; i < 40; i++) begin
            logic [15:0] m, q;
            int ak;
            m = 16'($urandom);
            q = 16'($urandom);
            if (i % 7 == 0) m = 16'hFFFF;
            if (i % 9 == 0) q = 16'h0000;
            ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
            do_op(m, q, ak, 0);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/shift_add_mul_ctrl.md
# shift_add_mul_ctrl

Sequencing controller for the 16-bit shift-and-add multiplier datapath. It accepts one unsigned multiply request through a start/busy/done handshake and owns the accumulator, multiplier and carry registers. It iterates one conditional add plus right shift per clock for WIDTH cycles, then publishes a registered 2*WIDTH-bit product. It sits between the request source and the and16/full_adder_16 style add-shift datapath and replaces the unrolled, unclocked chain with a single reused adder.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH bits; iteration counter is clog2(WIDTH) bits
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only in IDLE
- abort  in  1  cancel in-flight operation; synchronous, sampled every cycle
- multiplicand  in  WIDTH  operand M, captured on accepted start
- multiplier  in  WIDTH  operand Q, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, high while in DONE
- product  out  2*WIDTH  last completed result, registered, held until next completion

## Operation
- Reset (rst_n=0 at an edge): state=IDLE; A, Q, M, C, count=0; product=0; busy=0; done=0. Reset overrides start and abort.
- State IDLE:
  - If start=1 and abort=0: M<=multiplicand, Q<=multiplier, A<=0, C<=0, count<=0, go to RUN.
  - start=1 with abort=1 in the same cycle: ignored, stay IDLE.
- State RUN, once per cycle:
  - {C,A_sum} = Q[0] ? A+M : {0,A}, computed with a full WIDTH+1-bit carry.
  - Then {C,A,Q} <= {1'b0, C, A_sum, Q} >> 1. Q[WIDTH-1] takes A_sum[0]. A takes {C, A_sum[WIDTH-1:1]}.
  - count <= count+1.
  - When count==WIDTH-1 at the edge: product <= post-shift {A,Q}, go to DONE.
- State DONE: done=1 for exactly one cycle, then IDLE unconditionally. A start during DONE is ignored.
- Abort in RUN: go to IDLE next edge. product is unchanged and no done pulse occurs. In IDLE or DONE abort has no effect, and DONE still completes normally.
- Arithmetic: unsigned only. Result = multiplicand*multiplier exactly, so it never overflows 2*WIDTH bits. The carry is never dropped between iterations.
- The operand inputs may change freely after the accepting edge. Only the captured M and Q are used.
- product changes only on the RUN→DONE edge and on reset.

## Timing
- Accepting edge E0 (IDLE, start=1): busy=1 from E0 until edge E0+WIDTH.
- Iterations occur on edges E0+1 … E0+WIDTH.
- done=1 and the new product are valid in the cycle after edge E0+WIDTH.
- The next start is accepted no earlier than edge E0+WIDTH+2 (the first IDLE cycle).
- Throughput is one multiply per WIDTH+2 cycles.
- busy and done are never high together. Both are registered and decoded from state only.
- Reset asserted mid-RUN: at that edge all outputs return to reset values, including product=0.
- Abort at edge E0+k (1≤k≤WIDTH) while in RUN: IDLE follows, and busy=0 after that edge. An abort on the same edge as the final iteration (k=WIDTH) wins: product is not updated and no done pulse occurs.

## Test plan
- Basic multiply: WIDTH=16, M=3, Q=5, start pulse. Expected: busy high 16 cycles, then done for 1 cycle, product=0x0000000F held afterwards.
- Carry path: M=0xFFFF, Q=0xFFFF. Expected: product=0xFFFE0001. A second run with M=0x8000, Q=0x0002 gives product=0x00010000.
- Zero and identity: M=0, Q=0xABCD gives 0. M=0x1234, Q=1 gives 0x00001234. done timing is identical regardless of operand values.
- Handshake: start held high continuously with changing operands.
  - Expected: an op is accepted only in IDLE cycles, every WIDTH+2 cycles.
  - Each product matches the operands present at its accepting edge.
  - A start asserted during RUN or DONE is ignored.
- Abort: prior product=0x0000000F; start M=7, Q=9; abort at E0+8. Expected: busy drops, no done pulse, product stays 0x0000000F. Repeat the abort at E0+16: same result.
- Reset mid-operation: rst_n=0 at E0+5 during M=0xFFFF, Q=0xFFFF. Expected: state IDLE, busy=0, done=0, product=0. A fresh 3×5 afterwards completes normally with 15.
